// File: rtl/image_capture.sv
// image_capture: VSYNC/HSYNC pixel-stream sink writing 2 RGB888 pixels per beat into a bottom-up byte frame buffer
// Ports: HCLK/HRESET (sync, active-high); VSYNC rise arms a frame; HSYNC marks a beat on DATA_{R,G,B}{0,1}.
//        rd_addr/rd_data: registered byte read port (1-cycle latency, 0 beyond the frame).
//        busy, frame_done, err_unexp, err_abort, line_cnt, checksum: status.
// Optional macro CAPTURE_CHECKSUM_EN enables the 16-bit byte checksum; otherwise checksum is 0.
module image_capture #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  parameter int ADDR_W = 18
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              VSYNC,
  input  logic              HSYNC,
  input  logic [7:0]        DATA_R0,
  input  logic [7:0]        DATA_G0,
  input  logic [7:0]        DATA_B0,
  input  logic [7:0]        DATA_R1,
  input  logic [7:0]        DATA_G1,
  input  logic [7:0]        DATA_B1,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err_unexp,
  output logic              err_abort,
  output logic [15:0]       line_cnt,
  output logic [15:0]       checksum
);
  localparam int SIZE = WIDTH * HEIGHT * 3;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_CAPTURE = 2'd2, S_DONE = 2'd3;

  logic [7:0]        mem [SIZE];
  logic [1:0]        state_q, state_d;
  logic              vsync_q;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [15:0]       line_cnt_q, line_cnt_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              frame_done_q, frame_done_d;
  logic              err_unexp_q, err_unexp_d;
  logic              err_abort_q, err_abort_d;
  logic              rise, active, beat, eol, last;
  logic [ADDR_W-1:0] base;

  // A VSYNC rise takes priority: any beat in the same cycle is dropped.
  always_comb begin
    rise = VSYNC & ~vsync_q;
    active = (state_q == S_ARMED) || (state_q == S_CAPTURE);
    beat = HSYNC & ~rise & active;
    eol = col_q == CW'(WIDTH - 2);
    last = eol && (row_q == RW'(HEIGHT - 1));
    // Rows are stored bottom-up, so row 0 lands in the last line of the buffer.
    base = ADDR_W'(WIDTH * 3 * (HEIGHT - 1 - int'(row_q)) + 3 * int'(col_q));
    state_d = rise ? S_ARMED : beat ? (last ? S_DONE : S_CAPTURE) : state_q;
    col_d = rise ? '0 : beat ? (eol ? '0 : col_q + CW'(2)) : col_q;
    row_d = rise ? '0 : (beat && eol) ? row_q + RW'(1) : row_q;
    line_cnt_d = rise ? '0 : (beat && eol) ? line_cnt_q + 16'd1 : line_cnt_q;
    frame_done_d = rise ? 1'b0 : frame_done_q | (beat & last);
    err_unexp_d = err_unexp_q | (HSYNC & ~rise & ~active);
    err_abort_d = err_abort_q | (rise & (state_q == S_CAPTURE));
    rd_data_d = (32'(rd_addr) < SIZE) ? mem[rd_addr] : 8'h00;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      vsync_q <= 1'b0;
      row_q <= '0;
      col_q <= '0;
      line_cnt_q <= '0;
      rd_data_q <= '0;
      frame_done_q <= 1'b0;
      err_unexp_q <= 1'b0;
      err_abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= VSYNC;
      row_q <= row_d;
      col_q <= col_d;
      line_cnt_q <= line_cnt_d;
      rd_data_q <= rd_data_d;
      frame_done_q <= frame_done_d;
      err_unexp_q <= err_unexp_d;
      err_abort_q <= err_abort_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (beat) begin
      mem[base] <= DATA_R0;
      mem[base + ADDR_W'(1)] <= DATA_G0;
      mem[base + ADDR_W'(2)] <= DATA_B0;
      mem[base + ADDR_W'(3)] <= DATA_R1;
      mem[base + ADDR_W'(4)] <= DATA_G1;
      mem[base + ADDR_W'(5)] <= DATA_B1;
    end
  end

`ifdef CAPTURE_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;
  always_comb checksum_d = rise ? '0 : beat ? checksum_q + 16'(DATA_R0) + 16'(DATA_G0) + 16'(DATA_B0)
                                        + 16'(DATA_R1) + 16'(DATA_G1) + 16'(DATA_B1) : checksum_q;
  always_ff @(posedge HCLK) begin
    if (HRESET) checksum_q <= '0;
    else checksum_q <= checksum_d;
  end
  assign checksum = checksum_q;
`else
  assign checksum = 16'h0000;
`endif

  assign rd_data = rd_data_q;
  assign busy = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign frame_done = frame_done_q;
  assign err_unexp = err_unexp_q;
  assign err_abort = err_abort_q;
  assign line_cnt = line_cnt_q;
endmodule

// File: tb/tb_image_capture.sv
// tb_image_capture: scoreboard bench for image_capture with a pixel-index reference model
module tb_image_capture;
  localparam int W = 4, H = 2, AW = 5, SZ = W * H * 3, NB = W * H / 2;

  logic          HCLK = 1'b0, HRESET, VSYNC, HSYNC;
  logic [7:0]    r0, g0, b0, r1, g1, b1, rd_data;
  logic [AW-1:0] rd_addr;
  logic          busy, frame_done, err_unexp, err_abort;
  logic [15:0]   line_cnt, checksum;

  image_capture #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .VSYNC(VSYNC), .HSYNC(HSYNC),
    .DATA_R0(r0), .DATA_G0(g0), .DATA_B0(b0), .DATA_R1(r1), .DATA_G1(g1), .DATA_B1(b1),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .frame_done(frame_done),
    .err_unexp(err_unexp), .err_abort(err_abort), .line_cnt(line_cnt), .checksum(checksum)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0, errors = 0;
  logic [7:0]  m_mem [SZ];
  bit          m_known [SZ];
  bit          m_busy, m_done, m_unexp, m_abort;
  int          m_bc;
  logic [15:0] m_sum;
  logic [7:0]  rd_q [$];
  int          rd_aq [$];
  logic        rd_req = 1'b0, rd_pend = 1'b0;

  always @(posedge HCLK) rd_pend <= rd_req;

  // Monitor: every read issued one cycle earlier must show its expected byte now.
  always @(negedge HCLK) begin
    if (rd_pend) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_data unexpected output got %0h", rd_data);
      end else begin
        logic [7:0] e;
        int a;
        e = rd_q.pop_front();
        a = rd_aq.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data[%0d] got %0h expected %0h", a, rd_data, e);
        end
      end
    end
  end

  task automatic cyc;
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic status;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("frame_done", 32'(frame_done), 32'(m_done));
    chk("err_unexp", 32'(err_unexp), 32'(m_unexp));
    chk("err_abort", 32'(err_abort), 32'(m_abort));
    chk("line_cnt", 32'(line_cnt), 32'(m_bc / (W / 2)));
`ifdef CAPTURE_CHECKSUM_EN
    chk("checksum", 32'(checksum), 32'(m_sum));
`else
    chk("checksum", 32'(checksum), 32'h0);
`endif
  endtask

  task automatic model_reset;
    m_busy = 0; m_done = 0; m_unexp = 0; m_abort = 0; m_bc = 0; m_sum = 0;
  endtask

  // Pixel index k = 2*beat; row-major in stream order, stored bottom-up in the buffer.
  task automatic beat(input logic [47:0] px);
    {r0, g0, b0, r1, g1, b1} = px;
    HSYNC = 1'b1;
    if (m_busy) begin
      int k, a;
      k = 2 * m_bc;
      a = W * 3 * (H - 1 - k / W) + 3 * (k % W);
      for (int i = 0; i < 6; i++) begin
        m_mem[a + i] = px[47 - 8 * i -: 8];
        m_known[a + i] = 1'b1;
        m_sum = m_sum + 16'(px[47 - 8 * i -: 8]);
      end
      m_bc++;
      if (m_bc == NB) begin
        m_busy = 0;
        m_done = 1;
      end
    end else m_unexp = 1;
    cyc();
    HSYNC = 1'b0;
  endtask

  task automatic vrise;
    VSYNC = 1'b1;
    if (m_busy && m_bc > 0) m_abort = 1;
    m_busy = 1; m_bc = 0; m_done = 0; m_sum = 0;
    cyc();
    VSYNC = 1'b0;
  endtask

  task automatic rd(input int a);
    rd_addr = AW'(a);
    rd_req = 1'b1;
    rd_q.push_back(a < SZ ? m_mem[a] : 8'h00);
    rd_aq.push_back(a);
    cyc();
    rd_req = 1'b0;
  endtask

  task automatic rd_all;
    for (int a = 0; a < SZ; a++) if (m_known[a]) rd(a);
    rd(SZ);
    rd((1 << AW) - 1);
  endtask

  function automatic logic [47:0] rnd_px;
    return 48'({$urandom(), $urandom()});
  endfunction

  // mode 0: pixel k = (k, k+0x40, k+0x80); mode 1: random bytes.
  task automatic frame(input int mode, input int gap_min, input int gap_max);
    for (int b = 0; b < NB; b++) begin
      logic [7:0] k;
      k = 8'(2 * b);
      beat(mode == 0 ? {k, k + 8'h40, k + 8'h80, k + 8'h01, k + 8'h41, k + 8'h81} : rnd_px());
      status();
      repeat ($urandom_range(gap_max, gap_min)) cyc();
    end
  endtask

  task automatic do_reset;
    HRESET = 1'b1;
    model_reset();
    cyc();
    HRESET = 1'b0;
    status();
    chk("rd_data_rst", 32'(rd_data), 32'h0);
  endtask

  initial begin
    HRESET = 1'b1; VSYNC = 1'b0; HSYNC = 1'b0; rd_addr = '0;
    {r0, g0, b0, r1, g1, b1} = '0;
    model_reset();
    cyc();
    do_reset();
    vrise();
    status();
    frame(0, 0, 0);
    chk("line_cnt_full", 32'(line_cnt), 32'(H));
    rd_all();
    beat(rnd_px());
    status();
    rd_all();
    vrise();
    frame(1, 3, 3);
    rd_all();
    vrise();
    for (int i = 0; i < 3; i++) begin
      beat(rnd_px());
      status();
    end
    vrise();
    status();
    frame(1, 0, 0);
    rd_all();
    vrise();
    beat(rnd_px());
    beat(rnd_px());
    status();
    do_reset();
    beat(rnd_px());
    status();
    rd_all();
    vrise();
    frame(1, 0, 2);
    rd_all();
    cyc();
    cyc();
    chk("rd_queue_empty", 32'(rd_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
